calc_driver: RTL and testbench
==============================

Name: calc_driver

Overview:
- Command-side initiator for the calculator datapath.
- Accepts tagged calculation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives opcode and operands into the calculator, holding them stable across its one-cycle sampling register, then captures result and valid_res.
- Returns a tagged response with status over a valid/ready interface. Sits between the test/core command source and the calculator.

Parameters:
- DW, 32, operand width; result width is 2*DW.
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TW, 4, command/response tag width.

Ports:
- calc_clock  in  1  clock; all state on rising edge.
- calc_rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- cmd_opcode  in  3  opcode per shared package encoding.
- cmd_op1  in  DW  operand 1.
- cmd_op2  in  DW  operand 2.
- cmd_sel  in  1  SQRT operand select: 1=op1, 0=op2.
- cmd_tag  in  TW  tag echoed in response.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  2*DW  captured result.
- rsp_status  out  2  0=OK, 1=OVF, 2=ILLEGAL.
- rsp_tag  out  TW  tag of the command.
- calc_opcode  out  3  to calculator opcode.
- calc_op_in1  out  DW  to calculator op_in1.
- calc_op_in2  out  DW  to calculator op_in2.
- calc_op_in_sel  out  1  to calculator op_in_sel.
- calc_result  in  2*DW  from calculator result.
- calc_valid_res  in  1  from calculator valid_res (combinational, low on overflow).

Behaviour:
- Reset, asynchronous while calc_rst=0:
  - FIFO empty; state IDLE.
  - rsp_valid=0; rsp_result/rsp_status/rsp_tag=0.
  - calc_opcode=0; calc_op_in1/2=0; calc_op_in_sel=0.
  - cmd_ready=1 after reset.
  - Reset mid-operation discards the in-flight command and all queued commands; no response is emitted.
- FIFO:
  - Push on cmd_valid&&cmd_ready. Pop only in IDLE.
  - cmd_ready depends only on full; no bypass.
  - Push and pop in the same cycle are legal, including when full; occupancy is unchanged.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, SAMPLE, RESP.
  - IDLE:
    - If FIFO non-empty, pop the head into operand/opcode/tag registers.
    - Opcode in {SUM, MULT, SUB, SQRT} -> ISSUE.
    - Any other opcode (0, DIV=5, 6, 7) -> RESP with status ILLEGAL, result 0. No calculator issue occurs.
  - ISSUE:
    - calc_opcode = registered opcode; operands and sel driven from registers.
    - At the edge, latch ovf = !calc_valid_res -> SAMPLE.
  - SAMPLE:
    - Hold the same calculator inputs.
    - At the edge, rsp_result = ovf ? 0 : calc_result; rsp_status = ovf ? OVF : OK; rsp_tag = tag; rsp_valid=1 -> RESP.
  - RESP:
    - calc_opcode=0; operand lines hold their last values.
    - rsp_* stay stable while rsp_valid && !rsp_ready.
    - On handshake: rsp_valid=0 -> IDLE.
- calc_opcode is nonzero only in ISSUE and SAMPLE.
- Latency and throughput:
  - Command accepted at edge 0 into an empty FIFO with FSM in IDLE -> rsp_valid high after edge 3.
  - Illegal command -> rsp_valid high after edge 1.
  - Throughput is at most one command per 4 cycles.
- Responses return in command order.
- No arithmetic inside the block; widths pass through unchanged.

Decomposition:
- calc_pkg:
  - opcode enum (SUM=1, MULT=2, SUB=3, SQRT=4, DIV=5).
  - status enum (OK, OVF, ILLEGAL).
  - FSM state enum.
  - helper function is_issuable(opcode).
- Sub-module calc_cmd_fifo:
  - Parameterised width/depth synchronous FIFO, same clock and reset.
  - Stores {opcode, op1, op2, sel, tag}; exposes full/empty.

Test Plan:
- SUM op1=5 op2=7 tag=3, rsp_ready=1 -> rsp_result=12, status OK, tag 3; rsp_valid rises 3 cycles after acceptance.
- MULT op1=0xFFFFFFFF op2=2 -> rsp_result=0x1_FFFFFFFE, status OK. Also: SQRT op1=144 sel=1 -> rsp_result=12.
- SUM op1=0xFFFFFFFF op2=1 (calc_valid_res low) -> rsp_result=0, status OVF.
- opcode=5 (DIV), then opcode=0 -> two ILLEGAL responses with result 0; calc_opcode remains 0 throughout; each response 1 cycle after pop.
- rsp_ready=0, push 6 commands with tags 0..5 -> cmd_ready drops after 5 accepted (1 in flight + 4 queued); release rsp_ready -> responses with tags 0..5 in order, rsp_* stable while stalled.
- Assert calc_rst low during SAMPLE with 2 queued commands -> immediately rsp_valid=0, calc_opcode=0, cmd_ready=1; after release no response is produced.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator command driver: opcodes, response status,
// driver FSM states and the opcode legality check.
package calc_pkg;

    localparam int OPCODE_W = 3;
    localparam int STATUS_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 3'd0,
        OP_SUM  = 3'd1,
        OP_MULT = 3'd2,
        OP_SUB  = 3'd3,
        OP_SQRT = 3'd4,
        OP_DIV  = 3'd5
    } opcode_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK      = 2'd0,
        ST_OVF     = 2'd1,
        ST_ILLEGAL = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SAMPLE,
        S_RESP
    } state_e;

    // DIV exists in the encoding but the calculator behind this driver cannot run it.
    function automatic logic is_issuable(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_SUM, OP_MULT, OP_SUB, OP_SQRT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Small synchronous command FIFO with combinational head read and full/empty flags.
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push while full is only honoured when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/calc_driver.sv
// Command-side initiator: queues tagged commands, drives them into the calculator
// for its two-cycle sampling window, and returns a tagged result with status.
module calc_driver
    import calc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int TW    = 4
) (
    input  logic            calc_clock,
    input  logic            calc_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_opcode,
    input  logic [DW-1:0]   cmd_op1,
    input  logic [DW-1:0]   cmd_op2,
    input  logic            cmd_sel,
    input  logic [TW-1:0]   cmd_tag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_result,
    output logic [1:0]      rsp_status,
    output logic [TW-1:0]   rsp_tag,
    output logic [2:0]      calc_opcode,
    output logic [DW-1:0]   calc_op_in1,
    output logic [DW-1:0]   calc_op_in2,
    output logic            calc_op_in_sel,
    input  logic [2*DW-1:0] calc_result,
    input  logic            calc_valid_res
);

    localparam int FW = OPCODE_W + 2 * DW + 1 + TW;

    logic [FW-1:0]   fifo_rdata;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [2:0]      head_opc;
    logic [DW-1:0]   head_op1, head_op2;
    logic            head_sel;
    logic [TW-1:0]   head_tag;

    state_e          state_q, state_d;
    logic [2:0]      opc_q, opc_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            sel_q, sel_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic            ovf_q, ovf_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [2*DW-1:0] rsp_result_q, rsp_result_d;
    status_e         rsp_status_q, rsp_status_d;
    logic [TW-1:0]   rsp_tag_q, rsp_tag_d;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign {head_opc, head_op1, head_op2, head_sel, head_tag} = fifo_rdata;

    calc_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (calc_clock),
        .rst_ni  (calc_rst),
        .push_i  (fifo_push),
        .wdata_i ({cmd_opcode, cmd_op1, cmd_op2, cmd_sel, cmd_tag}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        sel_d        = sel_q;
        tag_d        = tag_q;
        ovf_d        = ovf_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        rsp_tag_d    = rsp_tag_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    opc_d = head_opc;
                    op1_d = head_op1;
                    op2_d = head_op2;
                    sel_d = head_sel;
                    tag_d = head_tag;
                    if (is_issuable(head_opc)) begin
                        state_d = S_ISSUE;
                    end else begin
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_status_d = ST_ILLEGAL;
                        rsp_tag_d    = head_tag;
                        state_d      = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                // Overflow is only flagged while the calculator sees the first cycle of inputs.
                ovf_d   = !calc_valid_res;
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                rsp_valid_d  = 1'b1;
                rsp_result_d = ovf_q ? '0 : calc_result;
                rsp_status_d = ovf_q ? ST_OVF : ST_OK;
                rsp_tag_d    = tag_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge calc_clock or negedge calc_rst) begin
        if (!calc_rst) begin
            state_q      <= S_IDLE;
            opc_q        <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            sel_q        <= 1'b0;
            tag_q        <= '0;
            ovf_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= ST_OK;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            opc_q        <= opc_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            sel_q        <= sel_d;
            tag_q        <= tag_d;
            ovf_q        <= ovf_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // Operand lines keep their last values; only the opcode marks an active request.
    assign calc_opcode    = (state_q == S_ISSUE || state_q == S_SAMPLE) ? opc_q : '0;
    assign calc_op_in1    = op1_q;
    assign calc_op_in2    = op2_q;
    assign calc_op_in_sel = sel_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;
    assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_calc_driver.sv
// Self-checking bench for calc_driver: directed vectors, stall/ordering and reset
// sequences, then randomized traffic against a scoreboard of expected responses.
module tb_calc_driver;

    localparam logic [2:0] SUM  = 3'd1;
    localparam logic [2:0] MULT = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] SQRT = 3'd4;
    localparam logic [2:0] DIV  = 3'd5;
    localparam logic [1:0] OK      = 2'd0;
    localparam logic [1:0] OVF     = 2'd1;
    localparam logic [1:0] ILLEGAL = 2'd2;

    typedef struct {
        logic [2:0]  opc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sel;
        logic [3:0]  tag;
        logic [63:0] expResult;
        logic [1:0]  expStatus;
    } vec_t;

    typedef struct packed {
        logic [63:0] result;
        logic [1:0]  status;
        logic [3:0]  tag;
    } rsp_t;

    typedef struct packed {
        logic [63:0] res;
        logic        ok;
    } math_t;

    logic        calc_clock = 1'b0;
    logic        calc_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic        cmd_sel;
    logic [3:0]  cmd_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [1:0]  rsp_status;
    logic [3:0]  rsp_tag;
    logic [2:0]  calc_opcode;
    logic [31:0] calc_op_in1;
    logic [31:0] calc_op_in2;
    logic        calc_op_in_sel;
    logic [63:0] calc_result;
    logic        calc_valid_res;

    int   checks   = 0;
    int   failures = 0;
    logic prevHeld = 1'b0;
    rsp_t held;
    rsp_t sb[$];
    vec_t vecs[10];
    math_t stubMath;

    calc_driver #(
        .DW    (32),
        .DEPTH (4),
        .TW    (4)
    ) dut (
        .calc_clock     (calc_clock),
        .calc_rst       (calc_rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_opcode     (cmd_opcode),
        .cmd_op1        (cmd_op1),
        .cmd_op2        (cmd_op2),
        .cmd_sel        (cmd_sel),
        .cmd_tag        (cmd_tag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_status     (rsp_status),
        .rsp_tag        (rsp_tag),
        .calc_opcode    (calc_opcode),
        .calc_op_in1    (calc_op_in1),
        .calc_op_in2    (calc_op_in2),
        .calc_op_in_sel (calc_op_in_sel),
        .calc_result    (calc_result),
        .calc_valid_res (calc_valid_res)
    );

    initial forever #5 calc_clock = ~calc_clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] isqrt(input logic [31:0] x);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) r = t;
        end
        return r;
    endfunction

    // Behaviour of the calculator as seen from the driver.
    function automatic math_t calcMath(input logic [2:0] opc, input logic [31:0] a,
                                       input logic [31:0] b, input logic sel);
        math_t m;
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        m.res = '0;
        m.ok  = 1'b1;
        case (opc)
            SUM: begin
                m.res = wa + wb;
                m.ok  = (m.res[63:32] == '0);
            end
            MULT: m.res = wa * wb;
            SUB: begin
                m.res = wa - wb;
                m.ok  = (a >= b);
            end
            SQRT: m.res = {32'd0, isqrt(sel ? a : b)};
            default: m.res = '0;
        endcase
        return m;
    endfunction

    function automatic rsp_t refModel(input logic [2:0] opc, input logic [31:0] a,
                                      input logic [31:0] b, input logic sel, input logic [3:0] tag);
        rsp_t r;
        math_t m;
        r.tag = tag;
        if (opc inside {SUM, MULT, SUB, SQRT}) begin
            m = calcMath(opc, a, b, sel);
            r.result = m.ok ? m.res : 64'd0;
            r.status = m.ok ? OK : OVF;
        end else begin
            r.result = '0;
            r.status = ILLEGAL;
        end
        return r;
    endfunction

    always_comb stubMath = calcMath(calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel);
    assign calc_result    = stubMath.res;
    assign calc_valid_res = stubMath.ok;

    task automatic step();
        @(posedge calc_clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkStable();
        if (prevHeld) begin
            checkOutput("stall_valid_stable",  64'(rsp_valid),  64'd1);
            checkOutput("stall_result_stable", rsp_result,      held.result);
            checkOutput("stall_status_stable", 64'(rsp_status), 64'(held.status));
            checkOutput("stall_tag_stable",    64'(rsp_tag),    64'(held.tag));
        end
        prevHeld    = rsp_valid && !rsp_ready;
        held.result = rsp_result;
        held.status = rsp_status;
        held.tag    = rsp_tag;
    endtask

    task automatic applyStimulus(input vec_t v);
        int   n;
        logic illegal;
        illegal    = !(v.opc inside {SUM, MULT, SUB, SQRT});
        rsp_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_opcode = v.opc;
        cmd_op1    = v.op1;
        cmd_op2    = v.op2;
        cmd_sel    = v.sel;
        cmd_tag    = v.tag;
        checkOutput("vec_cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 8) begin
            step();
            n++;
            if (illegal) checkOutput("illegal_calc_opcode_zero", 64'(calc_opcode), 64'd0);
            else if (n <= 2) checkOutput("issue_calc_opcode", 64'(calc_opcode), 64'(v.opc));
        end
        checkOutput("vec_latency", 64'(n), illegal ? 64'd1 : 64'd3);
        checkOutput("vec_result",  rsp_result,      v.expResult);
        checkOutput("vec_status",  64'(rsp_status), 64'(v.expStatus));
        checkOutput("vec_tag",     64'(rsp_tag),    64'(v.tag));
        checkOutput("resp_calc_opcode_zero", 64'(calc_opcode), 64'd0);
        step();
        checkOutput("vec_rsp_valid_cleared", 64'(rsp_valid), 64'd0);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int   nextTag;
        int   expTag;
        int   budget;
        logic sawStall;
        logic sawRsp;
        logic sawOpc;
        rsp_t exp;

        calc_rst   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_op1    = '0;
        cmd_op2    = '0;
        cmd_sel    = 1'b0;
        cmd_tag    = '0;
        rsp_ready  = 1'b0;

        vecs[0] = '{SUM,  32'd5,          32'd7,  1'b0, 4'd3,  64'd12,            OK};
        vecs[1] = '{MULT, 32'hFFFF_FFFF,  32'd2,  1'b0, 4'd1,  64'h1_FFFF_FFFE,   OK};
        vecs[2] = '{SQRT, 32'd144,        32'd9,  1'b1, 4'd2,  64'd12,            OK};
        vecs[3] = '{SUM,  32'hFFFF_FFFF,  32'd1,  1'b0, 4'd4,  64'd0,             OVF};
        vecs[4] = '{DIV,  32'd10,         32'd2,  1'b0, 4'd5,  64'd0,             ILLEGAL};
        vecs[5] = '{3'd0, 32'd10,         32'd2,  1'b0, 4'd6,  64'd0,             ILLEGAL};
        vecs[6] = '{SUB,  32'd10,         32'd3,  1'b0, 4'd7,  64'd7,             OK};
        vecs[7] = '{SQRT, 32'd16,         32'd81, 1'b0, 4'd8,  64'd9,             OK};
        vecs[8] = '{3'd7, 32'd1,          32'd1,  1'b1, 4'd9,  64'd0,             ILLEGAL};
        vecs[9] = '{SUB,  32'd3,          32'd10, 1'b0, 4'd10, 64'd0,             OVF};

        repeat (2) step();
        checkOutput("reset_rsp_valid",   64'(rsp_valid),      64'd0);
        checkOutput("reset_rsp_result",  rsp_result,          64'd0);
        checkOutput("reset_rsp_status",  64'(rsp_status),     64'd0);
        checkOutput("reset_rsp_tag",     64'(rsp_tag),        64'd0);
        checkOutput("reset_calc_opcode", 64'(calc_opcode),    64'd0);
        checkOutput("reset_calc_op1",    64'(calc_op_in1),    64'd0);
        checkOutput("reset_calc_op2",    64'(calc_op_in2),    64'd0);
        checkOutput("reset_calc_sel",    64'(calc_op_in_sel), 64'd0);
        checkOutput("reset_cmd_ready",   64'(cmd_ready),      64'd1);
        calc_rst = 1'b1;
        step();

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        $display("[TB] stall and ordering sequence");
        nextTag  = 0;
        expTag   = 0;
        sawStall = 1'b0;
        prevHeld = 1'b0;
        for (int c = 0; c < 80 && expTag < 6; c++) begin
            rsp_ready = (c >= 12);
            if (nextTag < 6) begin
                cmd_valid  = 1'b1;
                cmd_opcode = SUM;
                cmd_op1    = 32'(nextTag);
                cmd_op2    = 32'd100;
                cmd_sel    = 1'b0;
                cmd_tag    = 4'(nextTag);
            end else begin
                cmd_valid = 1'b0;
            end
            if (!sawStall && nextTag < 6 && !cmd_ready) begin
                sawStall = 1'b1;
                checkOutput("accepted_before_full", 64'(nextTag), 64'd5);
            end
            checkStable();
            if (cmd_valid && cmd_ready) nextTag++;
            if (rsp_valid && rsp_ready) begin
                checkOutput("order_tag",    64'(rsp_tag),    64'(expTag));
                checkOutput("order_result", rsp_result,      64'(expTag + 100));
                checkOutput("order_status", 64'(rsp_status), 64'(OK));
                expTag++;
            end
            step();
        end
        cmd_valid = 1'b0;
        checkOutput("stall_seen",    64'(sawStall), 64'd1);
        checkOutput("all_responses", 64'(expTag),   64'd6);
        prevHeld = 1'b0;
        repeat (2) step();

        $display("[TB] reset during sample");
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = SUM;
            cmd_op1    = 32'd1;
            cmd_op2    = 32'd2;
            cmd_sel    = 1'b0;
            cmd_tag    = 4'(7 + i);
            step();
        end
        cmd_valid = 1'b0;
        checkOutput("pre_reset_sample_opcode", 64'(calc_opcode), 64'(SUM));
        checkOutput("pre_reset_rsp_valid",     64'(rsp_valid),   64'd0);
        checkOutput("pre_reset_cmd_ready",     64'(cmd_ready),   64'd1);
        #1 calc_rst = 1'b0;
        #1;
        checkOutput("in_reset_rsp_valid",   64'(rsp_valid),   64'd0);
        checkOutput("in_reset_calc_opcode", 64'(calc_opcode), 64'd0);
        checkOutput("in_reset_cmd_ready",   64'(cmd_ready),   64'd1);
        #1 calc_rst = 1'b1;
        sawRsp = 1'b0;
        sawOpc = 1'b0;
        repeat (12) begin
            step();
            if (rsp_valid) sawRsp = 1'b1;
            if (calc_opcode != 3'd0) sawOpc = 1'b1;
        end
        checkOutput("no_rsp_after_reset",   64'(sawRsp), 64'd0);
        checkOutput("no_issue_after_reset", 64'(sawOpc), 64'd0);

        $display("[TB] randomized traffic");
        prevHeld = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cmd_valid  = ($urandom_range(0, 2) != 0);
            cmd_opcode = 3'($urandom_range(0, 7));
            cmd_op1    = randOperand();
            cmd_op2    = randOperand();
            cmd_sel    = 1'($urandom_range(0, 1));
            cmd_tag    = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            checkStable();
            if (calc_opcode != 3'd0) checkOutput("busy_no_rsp_valid", 64'(rsp_valid), 64'd0);
            if (cmd_valid && cmd_ready)
                sb.push_back(refModel(cmd_opcode, cmd_op1, cmd_op2, cmd_sel, cmd_tag));
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_response", 64'(rsp_valid), 64'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("rand_result", rsp_result,      exp.result);
                    checkOutput("rand_status", 64'(rsp_status), 64'(exp.status));
                    checkOutput("rand_tag",    64'(rsp_tag),    64'(exp.tag));
                end
            end
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        budget    = 200;
        while (sb.size() > 0 && budget > 0) begin
            if (rsp_valid) begin
                exp = sb.pop_front();
                checkOutput("drain_result", rsp_result,      exp.result);
                checkOutput("drain_status", 64'(rsp_status), 64'(exp.status));
                checkOutput("drain_tag",    64'(rsp_tag),    64'(exp.tag));
            end
            step();
            budget--;
        end
        checkOutput("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
        repeat (4) step();
        checkOutput("final_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("final_cmd_ready", 64'(cmd_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
